mips_divider: RTL and testbench

MIPS_DIVIDER -- requirements
Module: mips_divider

---
 rtl/mips_divider_pkg.sv | 17 +
 rtl/mips_divider_wide_subtractor.sv | 24 ++
 rtl/mips_divider.sv | 211 +++++++++++++++++++++
 tb/tb_mips_divider.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_divider_pkg.sv
// -----------------------------------------------------------------------------
// mips_divider_pkg
// Shared definitions for the MIPS DIV/DIVU sequential divider: the default
// operand width and the divider control state encoding.
// -----------------------------------------------------------------------------
package mips_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/mips_divider_wide_subtractor.sv
// -----------------------------------------------------------------------------
// wide_subtractor
// Unsigned W-bit subtract A - B with borrow-out. The divider uses it for the
// trial subtraction of each restoring step (borrow = partial remainder was
// smaller than the divisor).
//
// Ports
//   i_a      : minuend
//   i_b      : subtrahend
//   o_diff   : A - B modulo 2^W
//   o_borrow : 1 when A < B
// -----------------------------------------------------------------------------
module wide_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/mips_divider.sv
// -----------------------------------------------------------------------------
// mips_divider
// Multi-cycle restoring divider implementing MIPS DIV (signed, truncating) and
// DIVU. One quotient bit per cycle on operand magnitudes, followed by a sign
// fix-up cycle. Divide-by-zero bypasses the iteration loop.
//
// Ports
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : begin a divide (only honoured in IDLE)
//   is_signed    : 1 = DIV, 0 = DIVU (sampled with start)
//   dividend     : numerator (sampled with start)
//   divisor      : denominator (sampled with start)
//   flush        : abort any operation, results untouched
//   busy         : operation in progress
//   done         : one-cycle pulse when results are valid
//   div_by_zero  : last result came from a zero divisor; cleared by next start
//   quotient     : LO result, held until the next accepted start completes
//   remainder    : HI result, held likewise
//
// States
//   IDLE | waiting for start
//   BUSY | one restoring step per cycle, WIDTH cycles
//   FIX  | apply result signs, load output registers
//   DONE | results valid; divide-by-zero path loads outputs here
// -----------------------------------------------------------------------------
module mips_divider
    import mips_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    div_state_e       r_state;
    div_state_e       w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_work_q;
    logic [WIDTH-1:0] r_work_r;
    logic [WIDTH-1:0] r_dvs_mag;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_pend;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_load_fix;
    logic             w_load_dz;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_unused;

    // Operand magnitudes; unsigned operands pass straight through.
    assign w_dvs_zero = (divisor == '0);
    assign w_dvd_mag  = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dvs_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;

    // The dividend is shifted out of r_work_q into the partial remainder one
    // bit per step while quotient bits shift in from the bottom.
    assign w_shift = {r_work_r, r_work_q[WIDTH-1]};

    wide_subtractor #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_dvs_mag}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // The remainder is always below the divisor, so the top difference bit is
    // never needed.
    assign w_unused = w_diff[WIDTH];

    // The min/-1 case falls out naturally: magnitude quotient 2^(WIDTH-1)
    // negates back to itself.
    assign w_q_fixed = r_neg_q ? (~r_work_q + WIDTH'(1)) : r_work_q;
    assign w_r_fixed = r_neg_r ? (~r_work_r + WIDTH'(1)) : r_work_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_load_fix   = 1'b0;
        w_load_dz    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_dvs_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                w_load_fix   = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                w_load_dz    = r_dz_pend;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Flush wins over everything, including a simultaneous start.
        if (flush) begin
            w_next_state = IDLE;
            w_accept     = 1'b0;
            w_step       = 1'b0;
            w_load_fix   = 1'b0;
            w_load_dz    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_work_q      <= '0;
            r_work_r      <= '0;
            r_dvs_mag     <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz_pend     <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_load_fix | w_load_dz;

            if (w_accept) begin
                r_work_q      <= w_dvd_mag;
                // Zero divisor: park the raw dividend as the HI result.
                r_work_r      <= w_dvs_zero ? dividend : '0;
                r_dvs_mag     <= w_dvs_mag;
                r_neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r       <= is_signed & dividend[WIDTH-1];
                r_dz_pend     <= w_dvs_zero;
                r_cnt         <= w_dvs_zero ? '0 : CNT_LOAD;
                r_div_by_zero <= 1'b0;
            end else if (w_step) begin
                r_work_r <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_work_q <= {r_work_q[WIDTH-2:0], ~w_borrow};
                r_cnt    <= r_cnt - CNT_W'(1);
            end else if (flush) begin
                r_cnt <= '0;
            end

            if (w_load_fix) begin
                r_quotient  <= w_q_fixed;
                r_remainder <= w_r_fixed;
            end

            if (w_load_dz) begin
                r_quotient    <= '1;
                r_remainder   <= r_work_r;
                r_div_by_zero <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;

endmodule

// File: tb/tb_mips_divider.sv
module tb_mips_divider;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         start     = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush     = 1'b0;
    logic [W-1:0] dividend  = '0;
    logic [W-1:0] divisor   = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_checks = 0;
    int n_pass   = 0;

    mips_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truncating division from plain integer arithmetic.
    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            dz = 1'b0;
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = W'(sa / sb);
                r  = W'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Behavioural model: an accepted op completes a fixed number of edges
    // later (W+1, or 1 for a zero divisor); flush cancels it.
    logic         m_pending = 1'b0;
    logic         m_dz_op   = 1'b0;
    logic         m_done    = 1'b0;
    logic         m_last_dz = 1'b0;
    logic         m_dz      = 1'b0;
    logic         m_hold;
    int           m_left    = 0;
    logic [W-1:0] m_q       = '0;
    logic [W-1:0] m_r       = '0;
    logic [W-1:0] p_q       = '0;
    logic [W-1:0] p_r       = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pending = 1'b0;
            m_dz_op   = 1'b0;
            m_done    = 1'b0;
            m_last_dz = 1'b0;
            m_dz      = 1'b0;
            m_left    = 0;
            m_q       = '0;
            m_r       = '0;
        end else begin
            // The cycle showing done of a real divide still refuses start.
            m_hold = m_done && !m_last_dz;
            m_done = 1'b0;
            if (flush) begin
                m_pending = 1'b0;
            end else if (m_pending) begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 1'b0;
                    m_q       = p_q;
                    m_r       = p_r;
                    m_dz      = m_dz_op;
                    m_done    = 1'b1;
                    m_last_dz = m_dz_op;
                end
            end else if (start && !m_hold) begin
                ref_div(is_signed, dividend, divisor, p_q, p_r, m_dz_op);
                m_left    = m_dz_op ? 1 : W + 1;
                m_pending = 1'b1;
                m_dz      = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("done", done, m_done);
            chk("busy", busy, m_pending && !m_dz_op);
            chk("div_by_zero", div_by_zero, m_dz);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk({name, " done timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        logic seen;
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic seen;

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dz", div_by_zero, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        reset_n = 1'b1;

        issue(1'b0, 32'd100, 32'd7);
        wait_done("u100/7", lat);
        chk("u100/7 latency", lat, 33);
        chk("u100/7 q", quotient, 14);
        chk("u100/7 r", remainder, 2);
        chk("u100/7 dz", div_by_zero, 0);

        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done("s-100/7", lat);
        chk("s-100/7 q", quotient, 32'hFFFF_FFF2);
        chk("s-100/7 r", remainder, 32'hFFFF_FFFE);

        issue(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done("s100/-7", lat);
        chk("s100/-7 q", quotient, 32'hFFFF_FFF2);
        chk("s100/-7 r", remainder, 2);

        issue(1'b0, 32'h1234_5678, 32'd0);
        wait_done("div0", lat);
        chk("div0 latency", lat, 1);
        chk("div0 dz", div_by_zero, 1);
        chk("div0 q", quotient, 32'hFFFF_FFFF);
        chk("div0 r", remainder, 32'h1234_5678);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("min/-1", lat);
        chk("min/-1 q", quotient, 32'h8000_0000);
        chk("min/-1 r", remainder, 0);
        chk("min/-1 dz", div_by_zero, 0);

        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("umax/1", lat);
        chk("umax/1 q", quotient, 32'hFFFF_FFFF);
        chk("umax/1 r", remainder, 0);

        // Second start in the middle of busy must be ignored.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("ignored start busy", busy, 1);
        wait_done("ignored start", lat);
        chk("ignored start latency", lat, 23);
        chk("ignored start q", quotient, 333);
        chk("ignored start r", remainder, 1);

        // Flush mid-operation: no done, previous results kept.
        issue(1'b0, 32'd500, 32'd9);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("flush no done", seen, 0);
        chk("flush keeps q", quotient, 333);
        chk("flush keeps r", remainder, 1);

        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        dividend = 32'd40;
        divisor  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush+start busy", busy, 0);

        issue(1'b0, 32'd50, 32'd5);
        wait_done("after flush", lat);
        chk("after flush latency", lat, 33);
        chk("after flush q", quotient, 10);
        chk("after flush r", remainder, 0);

        // Reset in the middle of busy, then a fresh divide right away.
        issue(1'b1, 32'hFFFF_FFB3, 32'd4);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset dz", div_by_zero, 0);
        chk("midreset q", quotient, 0);
        chk("midreset r", remainder, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("9/3", lat);
        chk("9/3 latency", lat, 33);
        chk("9/3 q", quotient, 3);
        chk("9/3 r", remainder, 0);

        // Random traffic against the model.
        repeat (6000) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 150) == 0);
            is_signed = 1'($urandom_range(0, 1));
            dividend  = pick();
            divisor   = pick();
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
